// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and field layouts for the instruction fetch controller
package instr_fetch_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CMD       = 4'd1,
    ST_WAIT_STS  = 4'd2,
    ST_WAIT_CORE = 4'd3,
    ST_DONE      = 4'd4
  } fetch_state_e;

  // DataMover MM2S command word
  localparam int CMD_W         = 104;
  localparam int CMD_BTT_LSB   = 0;
  localparam int CMD_BTT_W     = 23;
  localparam int CMD_TYPE_BIT  = 23;
  localparam int CMD_DSA_LSB   = 24;
  localparam int CMD_DSA_W     = 6;
  localparam int CMD_EOF_BIT   = 30;
  localparam int CMD_DRR_BIT   = 31;
  localparam int CMD_SADDR_LSB = 32;
  localparam int CMD_SADDR_W   = 64;
  localparam int CMD_TAG_LSB   = 96;
  localparam int CMD_TAG_W     = 4;

  // DataMover status beat
  localparam int STS_W          = 8;
  localparam int STS_TAG_LSB    = 0;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_OKAY_BIT   = 7;

  // core_instr_status word
  localparam int STAT_CNT_W      = 12;
  localparam int STAT_RECV_LSB   = 0;
  localparam int STAT_ISSUED_LSB = 12;
  localparam int STAT_STATE_LSB  = 24;
  localparam int STAT_STATE_W    = 4;
  localparam int STAT_SLVERR_BIT = 28;
  localparam int STAT_DECERR_BIT = 29;
  localparam int STAT_INTERR_BIT = 30;
  localparam int STAT_ERR_BIT    = 31;

  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [CMD_TAG_W-1:0]   tag,
    input logic [CMD_SADDR_W-1:0] saddr,
    input logic [CMD_BTT_W-1:0]   btt
  );
    logic [CMD_W-1:0] c;
    c                               = '0;
    c[CMD_BTT_LSB +: CMD_BTT_W]     = btt;
    c[CMD_TYPE_BIT]                 = 1'b1;
    c[CMD_DSA_LSB +: CMD_DSA_W]     = '0;
    c[CMD_EOF_BIT]                  = 1'b1;
    c[CMD_DRR_BIT]                  = 1'b0;
    c[CMD_SADDR_LSB +: CMD_SADDR_W] = saddr;
    c[CMD_TAG_LSB +: CMD_TAG_W]     = tag;
    return c;
  endfunction

endpackage

// File: rtl/instr_chunk_splitter.sv
// rtl/instr_chunk_splitter.sv - walks an address/length region in chunks that never cross a CHUNK_BYTES boundary
module instr_chunk_splitter
  import instr_fetch_pkg::*;
#(
  parameter int CHUNK_BYTES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 load,
  input  logic [63:0]          load_addr,
  input  logic [31:0]          load_rem,
  input  logic                 advance,
  output logic [63:0]          addr,
  output logic [31:0]          rem,
  output logic [CMD_BTT_W-1:0] len
);

  localparam logic [31:0] CHUNK = 32'(CHUNK_BYTES);

  logic [63:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] to_bnd;

  always_comb begin
    // Bytes left before the next chunk boundary; CHUNK_BYTES is a power of two.
    to_bnd = CHUNK - (addr_q[31:0] & (CHUNK - 32'd1));
    len    = (rem_q < to_bnd) ? rem_q[CMD_BTT_W-1:0] : to_bnd[CMD_BTT_W-1:0];
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_addr;
      rem_d  = load_rem;
    end else if (advance) begin
      addr_d = addr_q + 64'(len);
      rem_d  = rem_q - 32'(len);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (clk_en) begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr = addr_q;
  assign rem  = rem_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - issues DataMover read commands for the instruction region and reports completion
module instr_fetch_ctrl
  import instr_fetch_pkg::*;
#(
  parameter int CHUNK_BYTES     = 4096,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              ap_start,
  input  logic [63:0]       instr_base_addr,
  input  logic [31:0]       instr_btt,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [CMD_W-1:0]  m_cmd_data,
  input  logic              s_sts_valid,
  output logic              s_sts_ready,
  input  logic [STS_W-1:0]  s_sts_data,
  input  logic              core_idle,
  output logic [31:0]       core_latency_cycles,
  output logic [31:0]       core_instr_status
);

  localparam int          OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] LAT_MAX = 32'hFFFF_FFFF;

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] received_q, received_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;
  logic             slverr_q, slverr_d;
  logic             decerr_q, decerr_d;
  logic             interr_q, interr_d;
  logic [31:0]      latency_q, latency_d;
  logic [31:0]      status_q, status_d;

  logic                 split_load;
  logic [63:0]          split_addr;
  logic [31:0]          split_rem;
  logic [CMD_BTT_W-1:0] split_len;

  logic cmd_fire;
  logic sts_take;
  logic sts_bad;
  logic sts_tag_unused;

  instr_chunk_splitter #(
    .CHUNK_BYTES(CHUNK_BYTES)
  ) u_splitter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .load      (split_load),
    .load_addr (instr_base_addr),
    .load_rem  (instr_btt),
    .advance   (cmd_fire),
    .addr      (split_addr),
    .rem       (split_rem),
    .len       (split_len)
  );

  assign m_cmd_valid = (state_q == ST_CMD) && !err_q && (split_rem != 32'd0)
                    && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign m_cmd_data  = pack_cmd(issued_q[CMD_TAG_W-1:0], split_addr, split_len);
  assign cmd_fire    = m_cmd_valid && m_cmd_ready;

  // Beats arriving in IDLE belong to an aborted run and are dropped.
  assign s_sts_ready    = 1'b1;
  assign sts_take       = s_sts_valid && (state_q != ST_IDLE);
  assign sts_bad        = !s_sts_data[STS_OKAY_BIT] || s_sts_data[STS_SLVERR_BIT]
                       || s_sts_data[STS_DECERR_BIT] || s_sts_data[STS_INTERR_BIT];
  assign sts_tag_unused = ^s_sts_data[STS_TAG_LSB +: CMD_TAG_W];

  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    slverr_d      = slverr_q;
    decerr_d      = decerr_q;
    interr_d      = interr_q;
    latency_d     = latency_q;
    split_load    = 1'b0;

    if (state_q != ST_IDLE && latency_q != LAT_MAX) begin
      latency_d = latency_q + 32'd1;
    end
    if (cmd_fire) begin
      issued_d = issued_q + CNT_W'(1);
    end
    if (sts_take) begin
      received_d = received_q + CNT_W'(1);
      if (sts_bad) begin
        err_d    = 1'b1;
        slverr_d = slverr_q | s_sts_data[STS_SLVERR_BIT];
        decerr_d = decerr_q | s_sts_data[STS_DECERR_BIT];
        interr_d = interr_q | s_sts_data[STS_INTERR_BIT];
      end
    end
    if (cmd_fire && !sts_take) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (sts_take && !cmd_fire && outstanding_q != '0) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          split_load    = 1'b1;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          err_d         = 1'b0;
          slverr_d      = 1'b0;
          decerr_d      = 1'b0;
          interr_d      = 1'b0;
          latency_d     = '0;
          state_d       = (instr_btt == 32'd0) ? ST_WAIT_CORE : ST_CMD;
        end
      end
      ST_CMD: begin
        if (err_q || (cmd_fire && split_rem == 32'(split_len))) begin
          state_d = ST_WAIT_STS;
        end
      end
      ST_WAIT_STS: begin
        // A failed run still drains its outstanding beats but skips the core wait.
        if (received_q == issued_q) begin
          state_d = err_q ? ST_DONE : ST_WAIT_CORE;
        end
      end
      ST_WAIT_CORE: begin
        if (core_idle) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    status_d                                    = '0;
    status_d[STAT_ERR_BIT]                      = err_d;
    status_d[STAT_INTERR_BIT]                   = interr_d;
    status_d[STAT_DECERR_BIT]                   = decerr_d;
    status_d[STAT_SLVERR_BIT]                   = slverr_d;
    status_d[STAT_STATE_LSB +: STAT_STATE_W]    = state_d;
    status_d[STAT_ISSUED_LSB +: STAT_CNT_W]     = STAT_CNT_W'(issued_d);
    status_d[STAT_RECV_LSB +: STAT_CNT_W]       = STAT_CNT_W'(received_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      slverr_q      <= 1'b0;
      decerr_q      <= 1'b0;
      interr_q      <= 1'b0;
      latency_q     <= '0;
      status_q      <= '0;
    end else if (clk_en) begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      slverr_q      <= slverr_d;
      decerr_q      <= decerr_d;
      interr_q      <= interr_d;
      latency_q     <= latency_d;
      status_q      <= status_d;
    end
  end

  assign ap_idle             = (state_q == ST_IDLE);
  assign ap_done             = (state_q == ST_DONE);
  assign ap_ready            = (state_q == ST_DONE);
  assign core_latency_cycles = latency_q;
  assign core_instr_status   = status_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

  localparam int CHUNK = 4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clk_en;
  logic         ap_start;
  logic [63:0]  instr_base_addr;
  logic [31:0]  instr_btt;
  logic         ap_done;
  logic         ap_idle;
  logic         ap_ready;
  logic         m_cmd_valid;
  logic         m_cmd_ready;
  logic [103:0] m_cmd_data;
  logic         s_sts_valid;
  logic         s_sts_ready;
  logic [7:0]   s_sts_data;
  logic         core_idle;
  logic [31:0]  core_latency_cycles;
  logic [31:0]  core_instr_status;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_addr[$];
  int          exp_len[$];

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clk_en              (clk_en),
    .ap_start            (ap_start),
    .instr_base_addr     (instr_base_addr),
    .instr_btt           (instr_btt),
    .ap_done             (ap_done),
    .ap_idle             (ap_idle),
    .ap_ready            (ap_ready),
    .m_cmd_valid         (m_cmd_valid),
    .m_cmd_ready         (m_cmd_ready),
    .m_cmd_data          (m_cmd_data),
    .s_sts_valid         (s_sts_valid),
    .s_sts_ready         (s_sts_ready),
    .s_sts_data          (s_sts_data),
    .core_idle           (core_idle),
    .core_latency_cycles (core_latency_cycles),
    .core_instr_status   (core_instr_status)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [103:0] mk_cmd(input int tag, input logic [63:0] a, input int len);
    return {4'h0, 4'(tag), a, 1'b0, 1'b1, 6'h00, 1'b1, 23'(len)};
  endfunction

  // Reference chunk list: cut at every CHUNK boundary until the byte count is used up.
  task automatic plan(input logic [63:0] base, input logic [31:0] btt);
    logic [63:0] a, r, room, l;
    exp_addr.delete();
    exp_len.delete();
    a = base;
    r = 64'(btt);
    while (r != 0) begin
      room = 64'(CHUNK) - (a % 64'(CHUNK));
      l    = (r < room) ? r : room;
      exp_addr.push_back(a);
      exp_len.push_back(int'(l));
      a = a + l;
      r = r - l;
    end
  endtask

  task automatic run_ok(input string nm, input logic [63:0] base, input logic [31:0] btt,
                        input bit rand_core, output int n_cmds, output int n_ticks);
    logic [3:0] sts_q[$];
    int issued, returned, total;
    plan(base, btt);
    total           = exp_addr.size();
    issued          = 0;
    returned        = 0;
    n_ticks         = 0;
    instr_base_addr = base;
    instr_btt       = btt;
    ap_start        = 1'b1;
    m_cmd_ready     = 1'b0;
    s_sts_valid     = 1'b0;
    s_sts_data      = 8'h00;
    core_idle       = 1'b1;
    while (n_ticks < 3000) begin
      tick();
      n_ticks++;
      if (ap_done) break;
      m_cmd_ready = ($urandom_range(0, 3) != 0);
      core_idle   = rand_core ? 1'($urandom_range(0, 1)) : 1'b1;
      s_sts_valid = (sts_q.size() > 0) && ($urandom_range(0, 2) != 0);
      s_sts_data  = s_sts_valid ? {4'b1000, sts_q[0]} : 8'h00;
      if (issued - returned >= 8) check({nm, "_outstanding_cap"}, m_cmd_valid, 0);
      if (m_cmd_valid && m_cmd_ready) begin
        check({nm, "_cmd_expected"}, exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) begin
          check({nm, "_cmd_data"}, m_cmd_data, mk_cmd(issued, exp_addr[0], exp_len[0]));
          sts_q.push_back(4'(issued));
          void'(exp_addr.pop_front());
          void'(exp_len.pop_front());
        end
        issued++;
      end
      if (s_sts_valid) begin
        void'(sts_q.pop_front());
        returned++;
      end
    end
    check({nm, "_done"}, ap_done, 1);
    ap_start    = 1'b0;
    s_sts_valid = 1'b0;
    m_cmd_ready = 1'b0;
    core_idle   = 1'b1;
    check({nm, "_ready_with_done"}, {ap_ready, ap_idle}, 2'b10);
    check({nm, "_all_issued"}, issued, total);
    check({nm, "_sts_drained"}, sts_q.size(), 0);
    check({nm, "_status"}, core_instr_status, {4'b0000, 4'd4, 12'(issued), 12'(issued)});
    tick();
    check({nm, "_done_pulse"}, {ap_done, ap_idle}, 2'b01);
    check({nm, "_latency"}, core_latency_cycles, n_ticks);
    n_cmds = issued;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, t, fires, drained;
    logic [63:0] rb;
    logic [31:0] rl;
    rst_n           = 1'b0;
    clk_en          = 1'b1;
    ap_start        = 1'b0;
    instr_base_addr = '0;
    instr_btt       = '0;
    m_cmd_ready     = 1'b0;
    s_sts_valid     = 1'b0;
    s_sts_data      = 8'h00;
    core_idle       = 1'b1;
    repeat (3) tick();
    check("rst_flags", {ap_idle, ap_done, ap_ready, m_cmd_valid, s_sts_ready}, 5'b10001);
    check("rst_latency", core_latency_cycles, 0);
    check("rst_status", core_instr_status, 0);
    rst_n = 1'b1;
    tick();

    run_ok("aligned_10000", 64'h1000, 32'd10000, 1'b0, n, t);
    check("aligned_10000_ncmd", n, 3);
    run_ok("straddle_64", 64'h0FF0, 32'd64, 1'b0, n, t);
    check("straddle_64_ncmd", n, 2);
    run_ok("zero_btt", 64'h2000, 32'd0, 1'b0, n, t);
    check("zero_btt_ncmd", n, 0);
    check("zero_btt_done_cycle", t, 2);

    for (int k = 0; k < 6; k++) begin
      rb = {$urandom, $urandom} & 64'h0000_FFFF_FFFF_FFFF;
      if (k % 2 == 1) rb[11:0] = 12'(CHUNK - $urandom_range(1, 64));
      rl = 32'($urandom_range(1, 24000));
      run_ok("rand", rb, rl, 1'b1, n, t);
      tick();
    end

    // Backpressure: no status returned caps issue at eight commands.
    instr_base_addr = 64'h0;
    instr_btt       = 32'd40960;
    ap_start        = 1'b1;
    m_cmd_ready     = 1'b1;
    fires           = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_cmd_valid && m_cmd_ready) fires++;
      tick();
    end
    check("bp_cap_fires", fires, 8);
    check("bp_cap_valid", m_cmd_valid, 0);
    s_sts_valid = 1'b1;
    s_sts_data  = 8'h80;
    tick();
    s_sts_valid = 1'b0;
    check("bp_reopen_valid", m_cmd_valid, 1);

    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ce_valid_held", m_cmd_valid, 1);
    check("ce_data_held", m_cmd_data, mk_cmd(8, 64'h8000, 4096));
    check("ce_latency_frozen", core_latency_cycles, 30);
    check("ce_status_frozen", core_instr_status, {4'b0000, 4'd1, 12'd8, 12'd1});
    clk_en = 1'b1;
    fires  = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_cmd_valid && m_cmd_ready) begin
        fires++;
        check("bp_cmd9_data", m_cmd_data, mk_cmd(8, 64'h8000, 4096));
      end
      tick();
    end
    check("bp_one_more", fires, 1);
    check("bp_status", core_instr_status, {4'b0000, 4'd1, 12'd9, 12'd1});
    check("bp_latency", core_latency_cycles, 40);

    rst_n    = 1'b0;
    ap_start = 1'b0;
    tick();
    check("midrst_flags", {ap_idle, ap_done, ap_ready, m_cmd_valid, s_sts_ready}, 5'b10001);
    check("midrst_latency", core_latency_cycles, 0);
    check("midrst_status", core_instr_status, 0);
    rst_n       = 1'b1;
    s_sts_valid = 1'b1;
    s_sts_data  = 8'h81;
    tick();
    s_sts_valid = 1'b0;
    tick();
    check("late_sts_discarded", core_instr_status, 0);

    // Error on the second status beat stops issue; run ends after the drain.
    instr_base_addr = 64'h0;
    instr_btt       = 32'd40960;
    ap_start        = 1'b1;
    m_cmd_ready     = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    m_cmd_ready = 1'b0;
    s_sts_valid = 1'b1;
    s_sts_data  = 8'h80;
    tick();
    s_sts_data = 8'hC1;
    tick();
    s_sts_valid = 1'b0;
    check("err_latched", core_instr_status, {4'b1001, 4'd1, 12'd8, 12'd2});
    m_cmd_ready = 1'b1;
    fires       = 0;
    drained     = 0;
    for (int i = 0; i < 40 && !ap_done; i++) begin
      if (m_cmd_valid && m_cmd_ready) fires++;
      if (drained < 6) begin
        s_sts_valid = 1'b1;
        s_sts_data  = {4'b1000, 4'(drained + 2)};
        drained++;
      end else begin
        s_sts_valid = 1'b0;
      end
      tick();
    end
    s_sts_valid = 1'b0;
    ap_start    = 1'b0;
    check("err_done", {ap_done, ap_ready}, 2'b11);
    check("err_no_more_cmds", fires, 0);
    check("err_drained_first", drained, 6);
    check("err_final_status", core_instr_status, {4'b1001, 4'd4, 12'd8, 12'd8});
    tick();
    check("err_back_idle", {ap_done, ap_idle}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sits directly downstream of the AXI-Lite control slave.
- On ap_start, splits the instruction region (instr_base_addr, instr_btt) into DataMover MM2S read commands and tracks the returned status beats.
- Waits for the core to drain, then reports ap_done/ap_idle/ap_ready plus latency and status words back to the control slave.

Parameters:
- CHUNK_BYTES, 4096: max bytes per command; power of two, ≤ 2^23-1; chunks never cross a CHUNK_BYTES boundary.
- MAX_OUTSTANDING, 8: max issued-but-unacknowledged commands.
- CNT_W, 12: width of the issued and received chunk counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- clk_en  in  1  global clock enable; when low, all state holds
- ap_start  in  1  level; held by the control slave until ap_done
- instr_base_addr  in  64  byte address of the instruction region; sampled at start
- instr_btt  in  32  byte count; sampled at start
- ap_done  out  1  one-cycle pulse at completion
- ap_idle  out  1  high in IDLE
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- m_cmd_valid  out  1  DataMover command valid
- m_cmd_ready  in  1  DataMover command ready
- m_cmd_data  out  104  {4'b0, tag[3:0], saddr[63:0], drr=0, eof=1, dsa=6'b0, type=1, btt[22:0]}
- s_sts_valid  in  1  status valid
- s_sts_ready  out  1  status ready
- s_sts_data  in  8  {okay, slverr, decerr, interr, tag[3:0]}
- core_idle  in  1  core has executed all fetched instructions
- core_latency_cycles  out  32  cycles of the last or current run
- core_instr_status  out  32  {err, interr, decerr, slverr, state[3:0], issued[11:0], received[11:0]}

Behaviour:
- Reset: rst_n is synchronous, active-low, on clock clk. State IDLE; ap_done=0; ap_ready=0; ap_idle=1; m_cmd_valid=0; s_sts_ready=1; all counters, error flags and the latency counter are 0.
- clk_en=0: no register updates. m_cmd_valid and m_cmd_data stay stable. Handshakes complete only on cycles where clk_en=1.
- IDLE: if ap_start=1, latch addr=instr_base_addr and rem=instr_btt, clear the counters, latency and error flags, then go to CMD. If instr_btt=0, go to WAIT_CORE and issue no command.
- CMD: m_cmd_valid=1 while outstanding<MAX_OUTSTANDING and no error is latched.
  - Chunk length len = min(rem, CHUNK_BYTES - (addr mod CHUNK_BYTES)).
  - Tag = issued[3:0].
  - On m_cmd_valid&m_cmd_ready: addr += len, rem -= len, issued++, outstanding++.
  - When rem reaches 0, go to WAIT_STS.
- Status handling: s_sts_ready=1 in every state. Each accepted beat does received++ and outstanding-- (outstanding saturates at 0 and is not decremented in IDLE).
  - If a beat has okay=0 or any error bit set, set err and OR the error bits into the sticky flags.
  - If a command and a status handshake fall in the same cycle, outstanding is unchanged.
- Error: once err is latched, no further commands are issued. The FSM leaves CMD for WAIT_STS immediately.
- WAIT_STS: when received==issued, go to WAIT_CORE. On error, go straight to DONE.
- WAIT_CORE: when core_idle=1, go to DONE.
- DONE: one cycle with ap_done=1 and ap_ready=1, then IDLE. If ap_start is still high in IDLE (auto-restart), a new run starts.
- Latency: increments each clk_en cycle while state≠IDLE, including DONE. Saturates at 0xFFFF_FFFF. Holds its value in IDLE until the next start.
- core_instr_status: registered; state encoding IDLE=0, CMD=1, WAIT_STS=2, WAIT_CORE=3, DONE=4.
- Reset mid-run: returns to IDLE at once; a command in flight is dropped; late status beats are accepted and discarded.

Decomposition:
- Package instr_fetch_pkg holds:
  - state enum
  - DataMover command field offsets and widths (btt 23, saddr 64, tag 4)
  - status bit positions
  - core_instr_status field positions
- One sub-module, instr_chunk_splitter: registered addr/rem plus the combinational len, with an advance strobe.

Test Plan:
- base=0x1000, btt=10000, sts always OK, core_idle=1 → 3 commands (len 4096, 4096, 1808; saddr 0x1000, 0x2000, 0x3000); ap_done pulses once; status issued=3, received=3, err=0.
- base=0x0FF0, btt=64 → 2 commands (len 16 @0x0FF0, len 48 @0x1000).
- btt=0 → no m_cmd_valid; core_idle=1 → ap_done 2 cycles after ap_start; latency=2.
- btt=40960, no status returned → exactly 8 commands issued, then m_cmd_valid=0; returning 1 status → exactly 1 more command.
- Second status beat carries slverr=1 → no further commands; after the outstanding statuses drain, ap_done pulses with err=1, slverr=1.
- clk_en held low for 5 cycles mid-CMD with m_cmd_ready=1 → no handshake, and latency and all counters are frozen; rst_n=0 mid-CMD → IDLE next cycle, ap_idle=1, all outputs at reset values.
